// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave controller:
// FSM state encoding, SDA mux codes, and output decode.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_RX,
    S_ADDR_CHK,
    S_ACK_WAIT,
    S_ACK_DRV,
    S_NACK_WAIT,
    S_NACK_DRV,
    S_LOAD,
    S_TX_DATA,
    S_MACK_WAIT,
    S_MACK_ACK,
    S_MACK_NACK,
    S_RX_DATA,
    S_RX_STORE,
    S_DACK_WAIT,
    S_DACK_DRV
  } state_t;

  localparam logic [1:0] SDA_RELEASE = 2'b00;
  localparam logic [1:0] SDA_LOW     = 2'b01;
  localparam logic [1:0] SDA_HIGH    = 2'b10;
  localparam logic [1:0] SDA_TX      = 2'b11;

  typedef struct packed {
    logic       rx_en;
    logic       tx_en;
    logic       load;
    logic       rx_wr;
    logic [1:0] sda;
  } ctrl_t;

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    c.sda = SDA_RELEASE;
    case (s)
      S_ADDR_RX,
      S_RX_DATA:  c.rx_en = 1'b1;
      S_ACK_DRV,
      S_DACK_DRV: c.sda = SDA_LOW;
      S_NACK_DRV: c.sda = SDA_HIGH;
      S_LOAD:     c.load = 1'b1;
      S_TX_DATA: begin
        c.tx_en = 1'b1;
        c.sda = SDA_TX;
      end
      S_RX_STORE: c.rx_wr = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_watchdog.sv
// Saturating bus-inactivity counter; flags the cycle
// that completes TIMEOUT_CYCLES quiet busy cycles.
module i2c_watchdog #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_WIDTH = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [TO_WIDTH-1:0] LIMIT =
    TO_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TO_WIDTH-1:0] LAST =
    TO_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit ON = TIMEOUT_CYCLES > 0;

  logic [TO_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != LIMIT) begin
      cnt <= cnt + TO_WIDTH'(1);
    end
  end

  assign timeout = ON && enable && !clear && (cnt >= LAST);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave sequencer: address, ACK/NACK, TX/RX bytes.
// Outputs are registered from the next-state decode.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int SUPPORT_WRITE = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_WIDTH = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       ack_prep,
  input  logic       check_ack,
  input  logic       ack_done,
  input  logic       rw_mode,
  input  logic       address_match,
  input  logic       sda_in,
  input  logic       tx_fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       read_enable,
  output logic       load_data,
  output logic       rx_write,
  output logic [1:0] sda_mode,
  output logic       busy
);

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   busy_q;
  logic   rw_q;
  logic   any_pulse;
  logic   timeout;
  logic   accept;

  assign any_pulse = start_found | stop_found
                   | byte_received | ack_prep
                   | check_ack | ack_done;

  assign accept = address_match
                & (rw_mode | (SUPPORT_WRITE != 0));

  i2c_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH(TO_WIDTH)
  ) u_wdog (
    .clk(clk),
    .n_rst(n_rst),
    .clear(any_pulse | ~busy_q),
    .enable(busy_q),
    .timeout(timeout)
  );

  always_comb begin
    nxt = state;
    if (stop_found || timeout) begin
      nxt = S_IDLE;
    end else if (start_found) begin
      nxt = S_ADDR_RX;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_ADDR_RX:
          if (byte_received) nxt = S_ADDR_CHK;
        S_ADDR_CHK:
          nxt = accept ? S_ACK_WAIT : S_NACK_WAIT;
        S_ACK_WAIT:
          if (ack_prep) nxt = S_ACK_DRV;
        S_ACK_DRV:
          if (ack_done) nxt = rw_q ? S_LOAD : S_RX_DATA;
        S_NACK_WAIT:
          if (ack_prep) nxt = S_NACK_DRV;
        S_NACK_DRV:
          if (ack_done) nxt = S_IDLE;
        S_LOAD:
          nxt = S_TX_DATA;
        S_TX_DATA:
          if (byte_received) nxt = S_MACK_WAIT;
        S_MACK_WAIT:
          if (check_ack)
            nxt = sda_in ? S_MACK_NACK : S_MACK_ACK;
        S_MACK_ACK:
          if (ack_done) nxt = S_LOAD;
        S_MACK_NACK:
          if (ack_done) nxt = S_IDLE;
        S_RX_DATA:
          if (byte_received) nxt = S_RX_STORE;
        S_RX_STORE:
          nxt = S_DACK_WAIT;
        S_DACK_WAIT:
          if (ack_prep) nxt = S_DACK_DRV;
        S_DACK_DRV:
          if (ack_done) nxt = S_RX_DATA;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= S_IDLE;
      ctrl   <= '0;
      busy_q <= 1'b0;
      rw_q   <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl   <= decode(nxt);
      busy_q <= (nxt != S_IDLE);
      if (state == S_ADDR_CHK) rw_q <= rw_mode;
    end
  end

  // An empty FIFO still loads the shifter default, just without a pop.
  assign read_enable = ctrl.load & ~tx_fifo_empty;
  assign rx_enable   = ctrl.rx_en;
  assign tx_enable   = ctrl.tx_en;
  assign load_data   = ctrl.load;
  assign rx_write    = ctrl.rx_wr;
  assign sda_mode    = ctrl.sda;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: table, directed sequences
// and random pulses against a transfer-level model.
module tb_i2c_slave_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  logic start_found, stop_found, byte_received;
  logic ack_prep, check_ack, ack_done;
  logic rw_mode, address_match, sda_in, tx_fifo_empty;

  logic rxe_a, txe_a, rd_a, ld_a, rxw_a, busy_a;
  logic [1:0] sda_a;
  logic rxe_b, txe_b, rd_b, ld_b, rxw_b, busy_b;
  logic [1:0] sda_b;

  i2c_slave_ctrl #(
    .SUPPORT_WRITE(1), .TIMEOUT_CYCLES(0), .TO_WIDTH(16)
  ) dut_a (
    .clk(clk), .n_rst(n_rst),
    .start_found(start_found), .stop_found(stop_found),
    .byte_received(byte_received), .ack_prep(ack_prep),
    .check_ack(check_ack), .ack_done(ack_done),
    .rw_mode(rw_mode), .address_match(address_match),
    .sda_in(sda_in), .tx_fifo_empty(tx_fifo_empty),
    .rx_enable(rxe_a), .tx_enable(txe_a),
    .read_enable(rd_a), .load_data(ld_a),
    .rx_write(rxw_a), .sda_mode(sda_a), .busy(busy_a)
  );

  i2c_slave_ctrl #(
    .SUPPORT_WRITE(0), .TIMEOUT_CYCLES(10), .TO_WIDTH(8)
  ) dut_b (
    .clk(clk), .n_rst(n_rst),
    .start_found(start_found), .stop_found(stop_found),
    .byte_received(byte_received), .ack_prep(ack_prep),
    .check_ack(check_ack), .ack_done(ack_done),
    .rw_mode(rw_mode), .address_match(address_match),
    .sda_in(sda_in), .tx_fifo_empty(tx_fifo_empty),
    .rx_enable(rxe_b), .tx_enable(txe_b),
    .read_enable(rd_b), .load_data(ld_b),
    .rx_write(rxw_b), .sda_mode(sda_b), .busy(busy_b)
  );

  // pulse vector order: start, stop, byte, prep, check, done
  localparam logic [5:0] PS = 6'b100000;
  localparam logic [5:0] PP = 6'b010000;
  localparam logic [5:0] PB = 6'b001000;
  localparam logic [5:0] PA = 6'b000100;
  localparam logic [5:0] PC = 6'b000010;
  localparam logic [5:0] PD = 6'b000001;
  localparam logic [5:0] PN = 6'b000000;

  typedef enum int {
    M_IDLE, M_ADDR, M_CHK, M_AW, M_AD, M_NW, M_ND, M_LD,
    M_TX, M_MW, M_MA, M_MN, M_RX, M_ST, M_DW, M_DD
  } mph_t;

  mph_t ph[2];
  int   quiet[2];
  logic rwl[2];
  int   cfg_sw[2] = '{1, 0};
  int   cfg_to[2] = '{0, 10};

  int n_pass = 0;
  int n_total = 0;
  int n_load, n_rd, n_rxw;

  typedef struct {
    logic [5:0] p;
    logic [1:0] a_sda;
    logic       a_busy;
    logic       a_rxw;
    logic [1:0] b_sda;
    logic       b_busy;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic logic [7:0] expect_out(int i);
    logic rx, tx, ld, wr;
    logic [1:0] s;
    rx = 0; tx = 0; ld = 0; wr = 0; s = 2'b00;
    case (ph[i])
      M_ADDR, M_RX: rx = 1;
      M_AD, M_DD:   s = 2'b01;
      M_ND:         s = 2'b10;
      M_LD:         ld = 1;
      M_TX: begin tx = 1; s = 2'b11; end
      M_ST:         wr = 1;
      default: ;
    endcase
    return {rx, tx, ld & ~tx_fifo_empty, ld, wr, s,
            ph[i] != M_IDLE};
  endfunction

  function automatic logic [7:0] dut_out(int i);
    if (i == 0)
      return {rxe_a, txe_a, rd_a, ld_a, rxw_a, sda_a, busy_a};
    return {rxe_b, txe_b, rd_b, ld_b, rxw_b, sda_b, busy_b};
  endfunction

  task automatic model_step(input int i);
    logic any;
    mph_t n;
    any = start_found | stop_found | byte_received
        | ack_prep | check_ack | ack_done;
    quiet[i] = (ph[i] != M_IDLE && !any) ? quiet[i] + 1 : 0;
    if (ph[i] == M_CHK) rwl[i] = rw_mode;
    n = ph[i];
    if (stop_found) n = M_IDLE;
    else if (cfg_to[i] > 0 && quiet[i] >= cfg_to[i]) n = M_IDLE;
    else if (start_found) n = M_ADDR;
    else begin
      case (ph[i])
        M_ADDR: if (byte_received) n = M_CHK;
        M_CHK:
          n = (address_match && (rw_mode || cfg_sw[i] != 0))
              ? M_AW : M_NW;
        M_AW: if (ack_prep) n = M_AD;
        M_AD: if (ack_done) n = rwl[i] ? M_LD : M_RX;
        M_NW: if (ack_prep) n = M_ND;
        M_ND: if (ack_done) n = M_IDLE;
        M_LD: n = M_TX;
        M_TX: if (byte_received) n = M_MW;
        M_MW: if (check_ack) n = sda_in ? M_MN : M_MA;
        M_MA: if (ack_done) n = M_LD;
        M_MN: if (ack_done) n = M_IDLE;
        M_RX: if (byte_received) n = M_ST;
        M_ST: n = M_DW;
        M_DW: if (ack_prep) n = M_DD;
        M_DD: if (ack_done) n = M_RX;
        default: ;
      endcase
    end
    ph[i] = n;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = M_IDLE;
      quiet[i] = 0;
      rwl[i] = 1'b0;
    end
  endtask

  task automatic apply(input logic [5:0] p, input logic rw,
                       input logic m, input logic s,
                       input logic e);
    {start_found, stop_found, byte_received,
     ack_prep, check_ack, ack_done} = p;
    rw_mode = rw;
    address_match = m;
    sda_in = s;
    tx_fifo_empty = e;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("model_a", 16'(dut_out(0)), 16'(expect_out(0)));
    check("model_b", 16'(dut_out(1)), 16'(expect_out(1)));
    if (ld_a) n_load++;
    if (rd_a) n_rd++;
    if (rxw_a) n_rxw++;
    {start_found, stop_found, byte_received,
     ack_prep, check_ack, ack_done} = PN;
  endtask

  int cnt;
  logic [5:0] rp;

  initial begin
    tbl[0]  = '{PS, 2'b00, 1, 0, 2'b00, 1};
    tbl[1]  = '{PB, 2'b00, 1, 0, 2'b00, 1};
    tbl[2]  = '{PN, 2'b00, 1, 0, 2'b00, 1};
    tbl[3]  = '{PA, 2'b01, 1, 0, 2'b10, 1};
    tbl[4]  = '{PD, 2'b00, 1, 0, 2'b00, 0};
    tbl[5]  = '{PB, 2'b00, 1, 1, 2'b00, 0};
    tbl[6]  = '{PN, 2'b00, 1, 0, 2'b00, 0};
    tbl[7]  = '{PA, 2'b01, 1, 0, 2'b00, 0};
    tbl[8]  = '{PD, 2'b00, 1, 0, 2'b00, 0};
    tbl[9]  = '{PB, 2'b00, 1, 1, 2'b00, 0};
    tbl[10] = '{PN, 2'b00, 1, 0, 2'b00, 0};
    tbl[11] = '{PA, 2'b01, 1, 0, 2'b00, 0};
    tbl[12] = '{PD, 2'b00, 1, 0, 2'b00, 0};
    tbl[13] = '{PP, 2'b00, 0, 0, 2'b00, 0};

    n_rst = 1'b0;
    {start_found, stop_found, byte_received,
     ack_prep, check_ack, ack_done} = PN;
    rw_mode = 0; address_match = 0;
    sda_in = 0; tx_fifo_empty = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", 16'(dut_out(0)), 16'h0);
    check("reset_b", 16'(dut_out(1)), 16'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // write transfer: two data bytes
    n_rxw = 0;
    for (int r = 0; r < 14; r++) begin
      apply(tbl[r].p, 0, 1, 0, 0);
      check($sformatf("tbl_row%0d", r),
            {9'h0, sda_a, busy_a, rxw_a, sda_b, busy_b},
            {9'h0, tbl[r].a_sda, tbl[r].a_busy, tbl[r].a_rxw,
             tbl[r].b_sda, tbl[r].b_busy});
    end
    check("write_rx_pulses", 16'(n_rxw), 16'd2);

    // read transfer: master ACKs byte 1, NACKs byte 2
    n_load = 0; n_rd = 0;
    apply(PS, 1, 1, 0, 0);
    apply(PB, 1, 1, 0, 0);
    apply(PN, 1, 1, 0, 0);
    apply(PA, 1, 1, 0, 0);
    check("read_ack_a", 16'(sda_a), 16'd1);
    check("read_ack_b", 16'(sda_b), 16'd1);
    apply(PD, 1, 1, 0, 0);
    apply(PN, 1, 1, 0, 0);
    check("read_tx_sda", 16'(sda_a), 16'd3);
    apply(PB, 1, 1, 0, 0);
    apply(PC, 1, 1, 0, 0);
    apply(PD, 1, 1, 0, 0);
    apply(PN, 1, 1, 0, 0);
    apply(PB, 1, 1, 0, 0);
    apply(PC, 1, 1, 1, 0);
    apply(PD, 1, 1, 1, 0);
    check("read_idle", 16'(busy_a), 16'd0);
    check("read_loads", 16'(n_load), 16'd2);
    check("read_pops", 16'(n_rd), 16'd2);

    // address mismatch
    apply(PS, 0, 0, 0, 0);
    apply(PB, 0, 0, 0, 0);
    apply(PN, 0, 0, 0, 0);
    apply(PA, 0, 0, 0, 0);
    check("nack_sda", 16'(sda_a), 16'd2);
    apply(PD, 0, 0, 0, 0);
    check("nack_idle", 16'(busy_a), 16'd0);

    // repeated start in TX_DATA, then coincident stop/start
    apply(PS, 1, 1, 0, 1);
    apply(PB, 1, 1, 0, 1);
    apply(PN, 1, 1, 0, 1);
    apply(PA, 1, 1, 0, 1);
    apply(PD, 1, 1, 0, 1);
    apply(PN, 1, 1, 0, 1);
    apply(PS, 1, 1, 0, 1);
    check("rstart_state", {14'h0, sda_a, rxe_a}, 16'h1);
    apply(PS | PP, 1, 1, 0, 1);
    check("stop_start_idle", 16'(busy_a), 16'd0);

    // asynchronous reset while driving data ACK
    apply(PS, 0, 1, 0, 0);
    apply(PB, 0, 1, 0, 0);
    apply(PN, 0, 1, 0, 0);
    apply(PA, 0, 1, 0, 0);
    apply(PD, 0, 1, 0, 0);
    apply(PB, 0, 1, 0, 0);
    apply(PN, 0, 1, 0, 0);
    apply(PA, 0, 1, 0, 0);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_sda", {14'h0, sda_a}, 16'h0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;

    // watchdog stall in ADDR_RX
    apply(PS, 0, 0, 0, 0);
    cnt = busy_b ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      apply(PN, 0, 0, 0, 0);
      if (!busy_b) break;
      cnt++;
    end
    check("wd_stall_cycles", 16'(cnt), 16'd10);
    apply(PP, 0, 0, 0, 0);

    // watchdog restart by a late byte_received
    apply(PS, 0, 0, 0, 0);
    repeat (8) apply(PN, 0, 0, 0, 0);
    apply(PB, 0, 0, 0, 0);
    cnt = busy_b ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      apply(PN, 0, 0, 0, 0);
      if (!busy_b) break;
      cnt++;
    end
    check("wd_restart_cycles", 16'(cnt), 16'd10);
    apply(PP, 0, 0, 0, 0);

    // random pulse traffic against the model
    for (int k = 0; k < 600; k++) begin
      rp = PN;
      rp[5] = ($urandom_range(0, 29) == 0);
      rp[4] = ($urandom_range(0, 39) == 0);
      for (int b = 0; b < 4; b++)
        rp[b] = ($urandom_range(0, 4) == 0);
      apply(rp, 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
